// File: rtl/cordic_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_arbiter_if
//  Purpose  : Bundles the requester-side and cordic-side signals of the
//             cordic_arbiter into one interface.
//  Ports    : req/req_x/req_y/req_theta   requester operands (in to arbiter)
//             gnt/rsp_valid/rsp_x/rsp_y/rsp_err/busy   arbiter status/results
//             cor_x/cor_y/cor_theta/cor_start          arbiter -> cordic
//             cor_xprime/cor_yprime/cor_done           cordic -> arbiter
//             slave modport = arbiter view, master modport = environment view
//  Revision : 1.0  initial release
// ============================================================================
interface cordic_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 16
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ*W-1:0] req_theta;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_x;
    logic [W-1:0]      rsp_y;
    logic              rsp_err;
    logic              busy;
    logic [W-1:0]      cor_x;
    logic [W-1:0]      cor_y;
    logic [W-1:0]      cor_theta;
    logic              cor_start;
    logic [W-1:0]      cor_xprime;
    logic [W-1:0]      cor_yprime;
    logic              cor_done;

    modport slave (
        input  req, req_x, req_y, req_theta, cor_xprime, cor_yprime, cor_done,
        output gnt, rsp_valid, rsp_x, rsp_y, rsp_err, busy,
               cor_x, cor_y, cor_theta, cor_start
    );

    modport master (
        output req, req_x, req_y, req_theta, cor_xprime, cor_yprime, cor_done,
        input  gnt, rsp_valid, rsp_x, rsp_y, rsp_err, busy,
               cor_x, cor_y, cor_theta, cor_start
    );
endinterface
`default_nettype wire

// File: rtl/cordic_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_arbiter
//  Purpose  : Shares a single rotational CORDIC among NREQ requesters.
//             Round-robin pick in IDLE, one-cycle grant/start in ISSUE, wait
//             for the core's done strobe (bounded by TIMEOUT) in WAIT, and a
//             one-cycle response pulse to the owner in RESP.
//  Ports    : clk    - clock, rising edge
//             reset  - synchronous active-high reset
//             bus    - cordic_arbiter_if.slave (requester + cordic signals)
//  Revision : 1.0  initial release
// ============================================================================
module cordic_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 32
) (
    input  wire logic          clk,
    input  wire logic          reset,
    cordic_arbiter_if.slave    bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_id;
    logic [TW-1:0]   r_timer;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_rsp_valid;
    logic [W-1:0]    r_rsp_x;
    logic [W-1:0]    r_rsp_y;
    logic            r_rsp_err;
    logic            r_busy;
    logic [W-1:0]    r_cor_x;
    logic [W-1:0]    r_cor_y;
    logic [W-1:0]    r_cor_theta;
    logic            r_cor_start;

    logic            w_any;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_idx;
    logic            w_timeout;

    // Round-robin winner: first set request scanning ptr, ptr+1, ... mod NREQ.
    // The loop runs from the farthest offset down so the nearest one wins.
    always_comb begin
        w_any = 1'b0;
        w_win = r_ptr;
        w_idx = r_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = IW'((int'(r_ptr) + k) % NREQ);
            if (bus.req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (bus.cor_done || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered on entry to the state they belong to, so the
    // grant/start pulse is visible during ISSUE and the response during RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_timer     <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_x     <= '0;
            r_rsp_y     <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_cor_x     <= '0;
            r_cor_y     <= '0;
            r_cor_theta <= '0;
            r_cor_start <= 1'b0;
        end else begin
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_cor_start <= 1'b0;
            r_busy      <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id        <= w_win;
                        r_gnt       <= NREQ'(1) << w_win;
                        r_cor_start <= 1'b1;
                        r_cor_x     <= bus.req_x[int'(w_win)*W +: W];
                        r_cor_y     <= bus.req_y[int'(w_win)*W +: W];
                        r_cor_theta <= bus.req_theta[int'(w_win)*W +: W];
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                end
                S_WAIT: begin
                    // Done in the final timeout cycle still counts as success.
                    if (bus.cor_done) begin
                        r_rsp_x     <= bus.cor_xprime;
                        r_rsp_y     <= bus.cor_yprime;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= NREQ'(1) << r_id;
                    end else if (w_timeout) begin
                        r_rsp_x     <= '0;
                        r_rsp_y     <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= NREQ'(1) << r_id;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RESP: begin
                    r_ptr <= (r_id == IW'(NREQ - 1)) ? '0 : r_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_x     = r_rsp_x;
    assign bus.rsp_y     = r_rsp_y;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = r_busy;
    assign bus.cor_x     = r_cor_x;
    assign bus.cor_y     = r_cor_y;
    assign bus.cor_theta = r_cor_theta;
    assign bus.cor_start = r_cor_start;
endmodule
`default_nettype wire

// File: tb/tb_cordic_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cordic_arbiter
//  Purpose  : Directed self-checking bench for cordic_arbiter (NREQ=4, W=16,
//             TIMEOUT=32). The bench plays both the requesters and the cordic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cordic_arbiter;
    localparam int NREQ    = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 32;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cordic_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    cordic_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0;
        bus.cor_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Advance until a grant is visible or the budget runs out.
    task automatic wait_gnt(output int n);
        n = 0;
        while (bus.gnt == '0 && n < 12) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req = 4'b1111;
        tick();
        tick();
        total++;
        if ({bus.gnt, bus.rsp_valid, bus.cor_start, bus.busy, bus.rsp_err} !== 11'd0) begin
            bad++;
            $display("FAIL reset_ctrl: got gnt=%b rsp_valid=%b start=%b busy=%b err=%b want all 0",
                     bus.gnt, bus.rsp_valid, bus.cor_start, bus.busy, bus.rsp_err);
        end
        total++;
        if ({bus.rsp_x, bus.rsp_y, bus.cor_x, bus.cor_y, bus.cor_theta} !== 80'd0) begin
            bad++;
            $display("FAIL reset_data: got rsp_x=%h rsp_y=%h cor_x=%h cor_y=%h cor_theta=%h want 0",
                     bus.rsp_x, bus.rsp_y, bus.cor_x, bus.cor_y, bus.cor_theta);
        end
        bus.req = '0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int ng;
        int nr;
        bus.req_x[2*W +: W]     = 16'd0;
        bus.req_y[2*W +: W]     = 16'd1;
        bus.req_theta[2*W +: W] = 16'd20;
        bus.req = 4'b0100;
        tick();
        total++;
        if (bus.gnt !== 4'b0100 || bus.cor_start !== 1'b1 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL single_gnt: got gnt=%b start=%b busy=%b want 0100 1 1",
                     bus.gnt, bus.cor_start, bus.busy);
        end
        total++;
        if (bus.cor_x !== 16'd0 || bus.cor_y !== 16'd1 || bus.cor_theta !== 16'd20) begin
            bad++;
            $display("FAIL single_operands: got %h %h %h want 0000 0001 0014",
                     bus.cor_x, bus.cor_y, bus.cor_theta);
        end
        bus.req = '0;
        ng = 1;
        nr = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.gnt != '0) ng++;
            if (bus.rsp_valid != '0) nr++;
        end
        bus.cor_xprime = 16'h1234;
        bus.cor_yprime = 16'h5678;
        bus.cor_done   = 1'b1;
        tick();
        bus.cor_done = 1'b0;
        total++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_x !== 16'h1234 || bus.rsp_y !== 16'h5678 ||
            bus.rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL single_rsp: got valid=%b x=%h y=%h err=%b want 0100 1234 5678 0",
                     bus.rsp_valid, bus.rsp_x, bus.rsp_y, bus.rsp_err);
        end
        total++;
        if (ng != 1 || nr != 0) begin
            bad++;
            $display("FAIL single_pulses: got grants=%0d early_rsp=%0d want 1 0", ng, nr);
        end
        tick();
        total++;
        if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0 || bus.rsp_x !== 16'h1234) begin
            bad++;
            $display("FAIL single_idle: got valid=%b busy=%b x=%h want 0000 0 1234",
                     bus.rsp_valid, bus.busy, bus.rsp_x);
        end
    endtask

    task automatic test_fairness();
        int n;
        int cnt [4];
        logic [3:0] g;
        logic [3:0] exp_g;
        logic [15:0] exp_x;
        cnt = '{0, 0, 0, 0};
        do_reset();
        bus.req = 4'b1111;
        for (int op = 0; op < 8; op++) begin
            wait_gnt(n);
            g = bus.gnt;
            exp_g = 4'(1 << (op % 4));
            if (op == 7) bus.req = '0;
            total++;
            if (g !== exp_g) begin
                bad++;
                $display("FAIL fair_gnt op%0d: got %b want %b", op, g, exp_g);
            end
            for (int d = 0; d <= op % 3; d++) tick();
            exp_x = 16'hA000 + 16'(op);
            bus.cor_xprime = exp_x;
            bus.cor_yprime = 16'hB000 + 16'(op);
            bus.cor_done   = 1'b1;
            tick();
            bus.cor_done = 1'b0;
            total++;
            if (bus.rsp_valid !== exp_g || bus.rsp_x !== exp_x || bus.rsp_err !== 1'b0) begin
                bad++;
                $display("FAIL fair_rsp op%0d: got valid=%b x=%h err=%b want %b %h 0",
                         op, bus.rsp_valid, bus.rsp_x, bus.rsp_err, exp_g, exp_x);
            end
            for (int i = 0; i < 4; i++) if (bus.rsp_valid[i]) cnt[i]++;
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cnt[i] != 2) begin
                bad++;
                $display("FAIL fair_count id%0d: got %0d want 2", i, cnt[i]);
            end
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        logic [3:0] g;
        bus.req = 4'b1000;
        wait_gnt(n);
        g = bus.gnt;
        bus.req = '0;
        total++;
        if (g !== 4'b1000) begin
            bad++;
            $display("FAIL to_gnt: got %b want 1000", g);
        end
        n = 0;
        while (bus.rsp_valid == '0 && n < TIMEOUT + 10) begin
            tick();
            n++;
        end
        total++;
        if (n != TIMEOUT + 1) begin
            bad++;
            $display("FAIL to_latency: got %0d cycles after start want %0d", n, TIMEOUT + 1);
        end
        total++;
        if (bus.rsp_valid !== 4'b1000 || bus.rsp_err !== 1'b1 || bus.rsp_x !== 16'd0 ||
            bus.rsp_y !== 16'd0) begin
            bad++;
            $display("FAIL to_rsp: got valid=%b err=%b x=%h y=%h want 1000 1 0000 0000",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_x, bus.rsp_y);
        end
        tick();
        bus.req = 4'b0001;
        wait_gnt(n);
        g = bus.gnt;
        bus.req = '0;
        total++;
        if (g !== 4'b0001) begin
            bad++;
            $display("FAIL to_next_gnt: got %b want 0001", g);
        end
        tick();
        bus.cor_xprime = 16'h0BEE;
        bus.cor_yprime = 16'h0F00;
        bus.cor_done   = 1'b1;
        tick();
        bus.cor_done = 1'b0;
        total++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_err !== 1'b0 || bus.rsp_x !== 16'h0BEE ||
            bus.rsp_y !== 16'h0F00) begin
            bad++;
            $display("FAIL to_next_rsp: got valid=%b err=%b x=%h y=%h want 0001 0 0bee 0f00",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_x, bus.rsp_y);
        end
        tick();
    endtask

    task automatic test_done_edge();
        int n;
        int nr;
        logic [3:0] g;
        bus.req = 4'b0010;
        wait_gnt(n);
        g = bus.gnt;
        bus.req = '0;
        total++;
        if (g !== 4'b0010) begin
            bad++;
            $display("FAIL edge_gnt: got %b want 0010", g);
        end
        nr = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            if (bus.rsp_valid != '0) nr++;
        end
        bus.cor_xprime = 16'hCAFE;
        bus.cor_yprime = 16'hF00D;
        bus.cor_done   = 1'b1;
        tick();
        bus.cor_done = 1'b0;
        total++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_err !== 1'b0 || bus.rsp_x !== 16'hCAFE ||
            bus.rsp_y !== 16'hF00D || nr != 0) begin
            bad++;
            $display("FAIL edge_rsp: got valid=%b err=%b x=%h y=%h early=%0d want 0010 0 cafe f00d 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_x, bus.rsp_y, nr);
        end
        tick();
        bus.cor_xprime = 16'h1111;
        bus.cor_yprime = 16'h2222;
        bus.cor_done   = 1'b1;
        tick();
        bus.cor_done = 1'b0;
        nr = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.rsp_valid != '0 || bus.busy != 1'b0) nr++;
            tick();
        end
        total++;
        if (nr != 0 || bus.rsp_x !== 16'hCAFE) begin
            bad++;
            $display("FAIL edge_stray_done: got active_cycles=%0d x=%h want 0 cafe", nr, bus.rsp_x);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int nr;
        logic [3:0] g;
        bus.req = 4'b0100;
        wait_gnt(n);
        g = bus.gnt;
        bus.req = '0;
        total++;
        if (g !== 4'b0100) begin
            bad++;
            $display("FAIL rmid_gnt: got %b want 0100", g);
        end
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({bus.gnt, bus.rsp_valid, bus.cor_start, bus.busy, bus.rsp_err} !== 11'd0 ||
            {bus.rsp_x, bus.rsp_y, bus.cor_x, bus.cor_y, bus.cor_theta} !== 80'd0) begin
            bad++;
            $display("FAIL rmid_outputs: got gnt=%b valid=%b busy=%b x=%h cor_x=%h want all 0",
                     bus.gnt, bus.rsp_valid, bus.busy, bus.rsp_x, bus.cor_x);
        end
        bus.cor_xprime = 16'h3333;
        bus.cor_done   = 1'b1;
        tick();
        bus.cor_done = 1'b0;
        nr = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.rsp_valid != '0) nr++;
            tick();
        end
        total++;
        if (nr != 0 || bus.rsp_x !== 16'd0) begin
            bad++;
            $display("FAIL rmid_late_done: got pulses=%0d x=%h want 0 0000", nr, bus.rsp_x);
        end
        bus.req = 4'b0010;
        wait_gnt(n);
        g = bus.gnt;
        bus.req = '0;
        total++;
        if (g !== 4'b0010 || n != 1) begin
            bad++;
            $display("FAIL rmid_next_gnt: got %b after %0d cycles want 0010 after 1", g, n);
        end
        tick();
        bus.cor_xprime = 16'h4444;
        bus.cor_done   = 1'b1;
        tick();
        bus.cor_done = 1'b0;
        total++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_x !== 16'h4444) begin
            bad++;
            $display("FAIL rmid_next_rsp: got valid=%b x=%h want 0010 4444", bus.rsp_valid, bus.rsp_x);
        end
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        bus.req        = '0;
        bus.cor_done   = 1'b0;
        bus.cor_xprime = '0;
        bus.cor_yprime = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_x[i*W +: W]     = 16'h1000 + 16'(i);
            bus.req_y[i*W +: W]     = 16'h2000 + 16'(i);
            bus.req_theta[i*W +: W] = 16'h3000 + 16'(i);
        end
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_done_edge();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
